// File: rtl/alu_cmd_driver.sv
// Command front-end for the alu: buffers valid/ready commands in a small FIFO,
// issues one at a time on the registered alu pins, captures the result and
// returns one tagged response per command. An IRQ-carrying response is followed
// by a single-cycle alu_irq_clr pulse.
module alu_cmd_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                         alu_clk,
  input  logic                         alu_rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_mode,
  input  logic [1:0]                   cmd_op,
  input  logic [7:0]                   cmd_a,
  input  logic [7:0]                   cmd_b,
  input  logic [TAG_W-1:0]             cmd_tag,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [7:0]                   rsp_data,
  output logic                         rsp_irq,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         alu_enable,
  output logic                         alu_enable_a,
  output logic                         alu_enable_b,
  output logic [1:0]                   alu_op_a,
  output logic [1:0]                   alu_op_b,
  output logic [7:0]                   alu_in_a,
  output logic [7:0]                   alu_in_b,
  output logic                         alu_irq_clr,
  input  logic [7:0]                   alu_out,
  input  logic                         alu_irq
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] OP1 = 2'b00;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StIssue   = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StResp    = 3'd3;
  localparam logic [2:0] StClear   = 3'd4;

  typedef struct packed {
    logic             mode;
    logic [1:0]       op;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [2:0]       r_state;
  logic             r_alu_enable;
  logic             r_alu_enable_a;
  logic             r_alu_enable_b;
  logic [1:0]       r_alu_op_a;
  logic [1:0]       r_alu_op_b;
  logic [7:0]       r_alu_in_a;
  logic [7:0]       r_alu_in_b;
  logic             r_alu_irq_clr;
  logic [TAG_W-1:0] r_cur_tag;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;
  logic             r_rsp_irq;
  logic [TAG_W-1:0] r_rsp_tag;

  cmd_t w_in;
  cmd_t w_head;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_in   = {cmd_mode, cmd_op, cmd_a, cmd_b, cmd_tag};
  assign w_head = r_mem[r_rd_ptr];
  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push = cmd_valid && !w_full;
  // The FIFO is only drained when the issue engine is idle.
  assign w_pop  = (r_state == StIdle) && (r_count != '0);

  assign cmd_ready    = !w_full;
  assign fifo_count   = r_count;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_irq      = r_rsp_irq;
  assign rsp_tag      = r_rsp_tag;
  assign alu_enable   = r_alu_enable;
  assign alu_enable_a = r_alu_enable_a;
  assign alu_enable_b = r_alu_enable_b;
  assign alu_op_a     = r_alu_op_a;
  assign alu_op_b     = r_alu_op_b;
  assign alu_in_a     = r_alu_in_a;
  assign alu_in_b     = r_alu_in_b;
  assign alu_irq_clr  = r_alu_irq_clr;

  // FIFO storage write; contents need no reset since the pointers gate every read.
  always_ff @(posedge alu_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge alu_clk) begin
    if (!alu_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM: drives the alu pins, captures the result and runs the response handshake.
  always_ff @(posedge alu_clk) begin
    if (!alu_rst_n) begin
      r_state        <= StIdle;
      r_alu_enable   <= 1'b0;
      r_alu_enable_a <= 1'b0;
      r_alu_enable_b <= 1'b0;
      r_alu_op_a     <= OP1;
      r_alu_op_b     <= OP1;
      r_alu_in_a     <= '0;
      r_alu_in_b     <= '0;
      r_alu_irq_clr  <= 1'b0;
      r_cur_tag      <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_irq      <= 1'b0;
      r_rsp_tag      <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_alu_enable   <= 1'b1;
            r_alu_enable_a <= !w_head.mode;
            r_alu_enable_b <= w_head.mode;
            // The opcode port of the unused path is parked at OP1.
            r_alu_op_a     <= w_head.mode ? OP1 : w_head.op;
            r_alu_op_b     <= w_head.mode ? w_head.op : OP1;
            r_alu_in_a     <= w_head.a;
            r_alu_in_b     <= w_head.b;
            r_cur_tag      <= w_head.tag;
            r_state        <= StIssue;
          end
        end
        StIssue: begin
          // Operands and opcodes stay put; only the enables drop.
          r_alu_enable   <= 1'b0;
          r_alu_enable_a <= 1'b0;
          r_alu_enable_b <= 1'b0;
          r_state        <= StCapture;
        end
        StCapture: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= alu_out;
          r_rsp_irq   <= alu_irq;
          r_rsp_tag   <= r_cur_tag;
          r_state     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_rsp_irq) begin
              r_alu_irq_clr <= 1'b1;
              r_state       <= StClear;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        StClear: begin
          r_alu_irq_clr <= 1'b0;
          r_state       <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: a stand-in ALU, a transaction-level
// scoreboard checked every cycle, and directed tests with literal expectations.
module tb_alu_cmd_driver;

  logic       clk = 1'b0;
  logic       alu_rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_mode;
  logic [1:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_tag;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_irq;
  logic [3:0] rsp_tag;
  logic [2:0] fifo_count;
  logic       alu_enable;
  logic       alu_enable_a;
  logic       alu_enable_b;
  logic [1:0] alu_op_a;
  logic [1:0] alu_op_b;
  logic [7:0] alu_in_a;
  logic [7:0] alu_in_b;
  logic       alu_irq_clr;
  logic [7:0] alu_out;
  logic       alu_irq;

  always #5 clk = ~clk;

  alu_cmd_driver #(
    .FIFO_DEPTH (4),
    .TAG_W      (4)
  ) u_dut (
    .alu_clk      (clk),
    .alu_rst_n    (alu_rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_tag      (cmd_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_irq      (rsp_irq),
    .rsp_tag      (rsp_tag),
    .fifo_count   (fifo_count),
    .alu_enable   (alu_enable),
    .alu_enable_a (alu_enable_a),
    .alu_enable_b (alu_enable_b),
    .alu_op_a     (alu_op_a),
    .alu_op_b     (alu_op_b),
    .alu_in_a     (alu_in_a),
    .alu_in_b     (alu_in_b),
    .alu_irq_clr  (alu_irq_clr),
    .alu_out      (alu_out),
    .alu_irq      (alu_irq)
  );

  typedef struct packed {
    logic       mode;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] tag;
  } cmd_s;

  int   n_checks = 0;
  int   n_fail   = 0;
  cmd_s iq[$];        // commands expected to appear on the alu pins
  cmd_s rq[$];        // commands expected to come back as responses
  logic [3:0] acc_tags[$];
  int   m_push = 0;
  int   m_pop  = 0;
  int   max_cnt = 0;

  // Stand-in ALU transfer function, per path and opcode.
  function automatic logic [7:0] ref_f(input logic mode, input logic [1:0] op,
                                       input logic [7:0] a, input logic [7:0] b);
    if (!mode) begin
      case (op)
        2'd0:    return a + b;
        2'd1:    return a - b;
        2'd2:    return a & b;
        default: return a ^ b;
      endcase
    end else begin
      case (op)
        2'd0:    return a | b;
        2'd1:    return b - a;
        2'd2:    return a + 8'd1;
        default: return a + b;
      endcase
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected/missing event, required none", name);
  endtask

  // Stand-in ALU: result registered on enable; B-path OP4 raises a sticky IRQ.
  always @(posedge clk) begin
    if (!alu_rst_n) begin
      alu_out <= 8'h00;
      alu_irq <= 1'b0;
    end else begin
      if (alu_enable && alu_enable_a) begin
        alu_out <= ref_f(1'b0, alu_op_a, alu_in_a, alu_in_b);
      end else if (alu_enable && alu_enable_b) begin
        alu_out <= ref_f(1'b1, alu_op_b, alu_in_a, alu_in_b);
        if (alu_op_b == 2'd3) alu_irq <= 1'b1;
      end
      if (alu_irq_clr) alu_irq <= 1'b0;
    end
  end

  // Per-cycle compare against the transaction model.
  initial begin
    logic       prev_en;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_irq;
    logic [3:0] prev_tag;
    cmd_s       c;
    prev_en    = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_irq   = 1'b0;
    prev_tag   = '0;
    forever begin
      @(negedge clk);
      if (!alu_rst_n) begin
        iq.delete();
        rq.delete();
        m_push     = 0;
        m_pop      = 0;
        prev_en    = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (alu_enable) begin
          chk("enable_back_to_back", 32'(prev_en), 32'd0);
          if (iq.size() == 0) begin
            fail_now("issue_without_command");
          end else begin
            c = iq.pop_front();
            m_pop++;
            chk("issue_pins", {alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b},
                {!c.mode, c.mode, c.mode ? 2'd0 : c.op, c.mode ? c.op : 2'd0, c.a, c.b});
          end
        end else begin
          chk("path_enable_idle", {alu_enable_a, alu_enable_b}, 32'd0);
        end
        chk("irq_clr_with_enable", 32'(alu_irq_clr && alu_enable), 32'd0);
        chk("fifo_count", 32'(fifo_count), 32'(m_push - m_pop));
        chk("cmd_ready", 32'(cmd_ready), 32'((m_push - m_pop) != 4));
        if ((m_push - m_pop) > max_cnt) max_cnt = m_push - m_pop;
        if (prev_stall) begin
          chk("rsp_stable", {rsp_valid, rsp_data, rsp_irq, rsp_tag},
              {1'b1, prev_data, prev_irq, prev_tag});
        end
        if (rsp_valid && rsp_ready) begin
          if (rq.size() == 0) begin
            fail_now("response_without_command");
          end else begin
            c = rq.pop_front();
            chk("rsp_fields", {rsp_data, rsp_irq, rsp_tag},
                {ref_f(c.mode, c.op, c.a, c.b), c.mode && (c.op == 2'd3), c.tag});
            acc_tags.push_back(rsp_tag);
          end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_data  = rsp_data;
        prev_irq   = rsp_irq;
        prev_tag   = rsp_tag;
        prev_en    = alu_enable;
        if (cmd_valid && cmd_ready) begin
          c = {cmd_mode, cmd_op, cmd_a, cmd_b, cmd_tag};
          iq.push_back(c);
          rq.push_back(c);
          m_push++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command and returns one cycle after it has been accepted.
  task automatic push(input logic m, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [3:0] tag);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail_now("push_timeout");
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (rq.size() == 0 && iq.size() == 0 && !rsp_valid && !alu_irq_clr && fifo_count == 0) break;
      n++;
    end
    if (n >= 400) fail_now(name);
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {cmd_ready, rsp_valid, rsp_data, rsp_irq, rsp_tag, fifo_count},
        {1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 3'd0});
    chk(name, {alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b,
               alu_irq_clr}, 32'd0);
  endtask

  initial begin
    logic [4:0] en_bits;
    logic [4:0] v_bits;
    logic [7:0] v8_bits;
    logic [7:0] clr_bits;
    logic [7:0] cap_data;
    logic       cap_irq;
    logic [3:0] cap_tag;
    logic [19:0] cap_pins;
    int         seen;

    alu_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 1'b0;
    cmd_op    = 2'd0;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    cmd_tag   = 4'h0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    alu_rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("power_on_reset");
    tick();

    // Mode A, OP4: 5A ^ 0F = 55, issue one cycle after push, response three cycles after.
    rsp_ready = 1'b0;
    push(1'b0, 2'd3, 8'h5A, 8'h0F, 4'd3);
    cap_data = '0; cap_irq = 1'b0; cap_tag = '0; cap_pins = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      en_bits[k] = alu_enable_a;
      v_bits[k]  = rsp_valid;
      if (k == 1) cap_pins = {alu_op_a, alu_op_b, alu_in_a, alu_in_b};
      if (k == 3) begin
        cap_data = rsp_data;
        cap_irq  = rsp_irq;
        cap_tag  = rsp_tag;
      end
    end
    chk("t2_enable_a_timing", 32'(en_bits), 32'b00010);
    chk("t2_rsp_valid_timing", 32'(v_bits), 32'b11000);
    chk("t2_issue_pins", 32'(cap_pins), {12'd0, 2'd3, 2'd0, 8'h5A, 8'h0F});
    chk("t2_rsp", {cap_data, cap_irq, cap_tag}, {8'h55, 1'b0, 4'd3});
    tick();
    rsp_ready = 1'b1;
    wait_idle("t2_drain_timeout");

    // Mode B, OP4 with IRQ: F0 + 0F = FF, one clear pulse right after the accept.
    rsp_ready = 1'b1;
    push(1'b1, 2'd3, 8'hF0, 8'h0F, 4'd7);
    cap_data = '0; cap_irq = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v8_bits[k]  = rsp_valid;
      clr_bits[k] = alu_irq_clr;
      if (k == 3) begin
        cap_data = rsp_data;
        cap_irq  = rsp_irq;
      end
    end
    chk("t3_rsp_valid_timing", 32'(v8_bits), 32'b0000_1000);
    chk("t3_irq_clr_pulse", 32'(clr_bits), 32'b0001_0000);
    chk("t3_rsp", {cap_data, cap_irq}, {8'hFF, 1'b1});
    tick();
    push(1'b0, 2'd0, 8'h01, 8'h02, 4'd8);
    wait_idle("t3_drain_timeout");

    // Full FIFO under backpressure: one in flight plus four queued.
    rsp_ready = 1'b0;
    acc_tags.delete();
    for (int i = 0; i < 5; i++) push(1'b0, 2'(i), 8'(8'h10 + i), 8'(8'h03 * i), 4'(i));
    cmd_valid = 1'b1;
    cmd_mode  = 1'b1;
    cmd_op    = 2'd0;
    cmd_a     = 8'h21;
    cmd_b     = 8'h42;
    cmd_tag   = 4'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_full_blocked", {cmd_ready, fifo_count, rsp_valid, rsp_tag},
          {1'b0, 3'd4, 1'b1, 4'd0});
    end
    tick();
    rsp_ready = 1'b1;
    push(1'b1, 2'd0, 8'h21, 8'h42, 4'd5);
    wait_idle("t4_drain_timeout");
    chk("t4_rsp_count", 32'(acc_tags.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < acc_tags.size()) chk("t4_tag_order", 32'(acc_tags[i]), 32'(i));
    end

    // Reset mid-response with three commands queued: everything dropped.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 2'd0, 8'(i), 8'h01, 4'(i + 10));
    @(negedge clk);
    chk("t1_before_reset", {fifo_count, rsp_valid}, {3'd3, 1'b1});
    tick();
    alu_rst_n = 1'b0;
    tick();
    alu_rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("t1_after_reset");
    tick();
    rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid || alu_enable) seen++;
    end
    chk("t1_no_dropped_activity", 32'(seen), 32'd0);
    tick();

    // Ten commands streaming through, wrapping the pointers, with IRQs mixed in.
    rsp_ready = 1'b1;
    acc_tags.delete();
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      push(1'(i % 2), 2'(i % 4), 8'(i * 17 + 3), 8'(8'h40 - i), 4'(i));
    end
    wait_idle("t5_drain_timeout");
    chk("t5_max_count", 32'(max_cnt), 32'd4);
    chk("t5_rsp_count", 32'(acc_tags.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < acc_tags.size()) chk("t5_tag_order", 32'(acc_tags[i]), 32'(i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
